// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: widths, access-size encodings and controller states.
package load_store_unit_pkg;

  localparam int unsigned XLEN_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_R = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_ADDR = 3'd1,
    LD_DATA = 3'd2,
    ST_BYTE = 3'd3,
    ERR     = 3'd4
  } lsu_state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

  // Index of the final byte of a store.
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load result formatting: selects byte/half/word from RAM read data and extends it.
module load_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_WIDTH
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      SIZE_B:  data_o = {{(XLEN-8){~unsigned_i & rdata_i[7]}}, rdata_i[7:0]};
      SIZE_H:  data_o = {{(XLEN-16){~unsigned_i & rdata_i[15]}}, rdata_i[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end: serialises stores into byte writes, issues loads on the RAM read port.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses are rejected with resp_err.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TrapMisalign = 1'b1;
`else
  localparam bit TrapMisalign = 1'b0;
`endif

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]      size_q, size_d, cnt_q, cnt_d, cnt_nxt;
  logic            uns_q, uns_d;
  logic            ready_q, ready_d, rvalid_q, rvalid_d, rerr_q, rerr_d, we_q, we_d;
  logic [XLEN-1:0] rdata_q, rdata_d, maddr_q, maddr_d, waddr_q, waddr_d, wbyte_q, wbyte_d;
  logic [XLEN-1:0] load_data;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata_i   (mem_rdata),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (load_data)
  );

  assign cnt_nxt = cnt_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    uns_d    = uns_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = '0;
    we_d     = 1'b0;
    waddr_d  = '0;
    wbyte_d  = '0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          cnt_d   = 2'd0;
          if ((req_size == SIZE_R) || (TrapMisalign && misaligned(req_size, req_addr[1:0]))) begin
            state_d = ERR;
          end else if (req_we) begin
            // First byte is presented straight from the request so it commits at E1.
            state_d = ST_BYTE;
            we_d    = 1'b1;
            waddr_d = req_addr;
            wbyte_d = {{(XLEN-8){1'b0}}, req_wdata[7:0]};
          end else begin
            state_d = LD_ADDR;
            maddr_d = req_addr;
          end
        end
      end
      LD_ADDR: state_d = LD_DATA;
      LD_DATA: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        rvalid_d = 1'b1;
        rdata_d  = load_data;
      end
      ST_BYTE: begin
        if (cnt_q < last_byte(size_q)) begin
          cnt_d   = cnt_nxt;
          we_d    = 1'b1;
          waddr_d = addr_q + XLEN'(cnt_nxt);
          wbyte_d = {{(XLEN-8){1'b0}}, wdata_q[{cnt_nxt, 3'b000} +: 8]};
        end else begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          rvalid_d = 1'b1;
        end
      end
      ERR: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        rvalid_d = 1'b1;
        rerr_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wbyte_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wbyte_q  <= wbyte_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = maddr_q;
  assign mem_we     = we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wbyte_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte RAM model, transaction-level reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_we;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Byte RAM: one write port, one registered 4-byte unaligned read port (index wraps at 1 KiB).
  logic [7:0] ram [0:1023] = '{default: 8'h00};
  logic [7:0] ref_mem [0:1023] = '{default: 8'h00};
  logic [9:0] ra;
  assign ra = mem_addr[9:0];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr[9:0]] <= mem_wdata[7:0];
    mem_rdata <= {ram[ra + 10'd3], ram[ra + 10'd2], ram[ra + 10'd1], ram[ra]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] data; int due; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int vectors = 0;
  int miscompares = 0;
  int last_accept = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected responses and writes as the DUT presents them.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (resp_valid) begin
        if (rq.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
        else begin
          resp_t e;
          e = rq.pop_front();
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("resp_rdata", resp_rdata, e.data);
          check("resp_cycle", cyc, e.due);
          last_rdata = resp_rdata;
        end
      end
      if (mem_we) begin
        if (wq.size() == 0) check("unexpected_write", mem_waddr, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = wq.pop_front();
          check("mem_waddr", mem_waddr, w.addr);
          check("mem_wdata", mem_wdata, w.data);
          check("write_cycle", cyc, w.due);
        end
      end
    end
  end

  // Reference: expectations from the access rules, applied to a transaction-level memory.
  task automatic expect_txn(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, input int k);
    int n;
    logic [31:0] v, m;
    bit mis;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
    if (sz == 2'd3 || (TRAP && mis)) begin
      rq.push_back('{1'b1, 32'd0, k + 2});
    end else if (we) begin
      for (int i = 0; i < n; i++) begin
        wr_t w;
        w.addr = a + 32'(i);
        w.data = (wd >> (8 * i)) & 32'hFF;
        w.due  = k + 1 + i;
        wq.push_back(w);
        ref_mem[w.addr[9:0]] = w.data[7:0];
      end
      rq.push_back('{1'b0, 32'd0, k + 1 + n});
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        logic [31:0] ai;
        ai = a + 32'(i);
        v = v | (32'(ref_mem[ai[9:0]]) << (8 * i));
      end
      if (n < 4) begin
        m = (32'd1 << (8 * n)) - 32'd1;
        if (!uns && v[8*n-1]) v = v | ~m;
      end
      rq.push_back('{1'b0, v, k + 3});
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      expect_txn(we, sz, uns, a, wd, cyc);
      last_accept = cyc + 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rq.size() != 0 || wq.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", rq.size() + wq.size(), 32'd0);
    rq.delete();
    wq.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_resp"}, {30'd0, resp_valid, resp_err}, 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_waddr"}, mem_waddr | mem_wdata, 32'd0);
  endtask

  initial begin
    int acc1, diffs;
    logic [7:0] saved [0:2];
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    check("ready_before_edge", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Directed: word store then loads around it.
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    go_idle();
    drain();
    check("plan_word_load", last_rdata, 32'hDEADBEEF);
    issue(1'b0, 2'd0, 1'b0, 32'h103, 0); go_idle(); drain();
    check("plan_sbyte", last_rdata, 32'hFFFFFFDE);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 0); go_idle(); drain();
    check("plan_ubyte", last_rdata, 32'h000000DE);
    issue(1'b0, 2'd1, 1'b0, 32'h102, 0); go_idle(); drain();
    check("plan_shalf", last_rdata, 32'hFFFFDEAD);
    issue(1'b0, 2'd1, 1'b1, 32'h100, 0); go_idle(); drain();
    check("plan_uhalf", last_rdata, 32'h0000BEEF);
    issue(1'b1, 2'd0, 1'b0, 32'h104, 32'h5A);
    issue(1'b0, 2'd2, 1'b0, 32'h101, 0); go_idle(); drain();
    check("plan_misaligned_word", last_rdata, TRAP ? 32'h0 : 32'h5ADEADBE);
    issue(1'b1, 2'd3, 1'b0, 32'h120, 32'h12345678); go_idle(); drain();
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hA1B2C3D4); go_idle(); drain();

    // Back-to-back loads with req_valid held.
    issue(1'b0, 2'd2, 1'b0, 32'h100, 0);
    acc1 = last_accept;
    issue(1'b0, 2'd1, 1'b1, 32'h102, 0);
    check("b2b_accept_gap", last_accept - acc1, 32'd3);
    go_idle();
    drain();

    // Reset between E1 and E2 of a word store.
    for (int i = 0; i < 3; i++) saved[i] = ref_mem[10'h201 + 10'(i)];
    issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    check("dropped_writes", wq.size(), 32'd3);
    rq.delete();
    wq.delete();
    for (int i = 0; i < 3; i++) ref_mem[10'h201 + 10'(i)] = saved[i];
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midop_reset", {31'd0, req_ready}, 32'd1);
    check("reset_byte0_written", {24'd0, ram[10'h200]}, 32'h44);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 1023)), $urandom);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    drain();

    diffs = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) diffs++;
    check("ram_image_diffs", diffs, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
